fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that owns the architectural fetch PC, issues single-outstanding requests to instruction memory, and buffers returned instructions in a small queue for ID. It sits directly upstream of the branch predictor: `fetch_pc` drives the predictor's `pc` input, and the predictor's `target_pc` returns as `npc` to advance or redirect the PC. The unit drops in-flight responses on a redirect from misprediction or exception and flushes its queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `QDEPTH`, default 2: instruction-queue entries; a power of two ≥ 2.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-low; one clock, synchronous active-low reset.
- `npc`  in  32  next PC from the predictor. It is `target_pc`, with exception and mispredict already muxed in.
- `redirect`  in  1  flush pulse from predict_fail or excp.
- `fetch_pc`  out  32  current fetch PC, fed to the predictor.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  request address; equals `fetch_pc`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; at least 1 cycle after the grant.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  queue head valid to ID.
- `if_pc`  out  32  PC of head instruction.
- `if_inst`  out  32  head instruction.
- `id_ready`  in  1  ID consumes head when `if_valid & id_ready`.

## Operation
- FSM states:
  - BOOT: one idle cycle after reset release; `imem_req`=0; next state IDLE. This gives the predictor a cold first cycle.
  - IDLE: `imem_req` = `~redirect & (occupancy < QDEPTH)`. On `imem_req & imem_gnt`:
    - latch `req_pc`←`fetch_pc`;
    - `fetch_pc`←`npc`;
    - next state WAIT.
  - WAIT: `imem_req`=0. On `imem_rvalid`:
    - if `drop`=1, discard the word and clear `drop`;
    - else push {`req_pc`, `imem_rdata`}.
    - Next state IDLE.
- Space reservation: a request is issued only when the queue has a free slot. Occupancy counts entries only, because at most one response is outstanding and it is issued only with a free slot. A pop in the same cycle as a push is always legal.
- Redirect, in any state except BOOT:
  - `fetch_pc`←`npc`;
  - queue emptied; `if_valid`=0 next cycle;
  - the same-cycle pop is ignored;
  - in WAIT, `drop`←1 unless `imem_rvalid` is also high that cycle, in which case that word is discarded and `drop` stays 0.
- Redirect has priority over push, pop and grant.
- Queue: circular buffer, `QDEPTH`-entry; read/write pointers are log2(`QDEPTH`) bits and wrap modulo `QDEPTH`; occupancy counter is log2(`QDEPTH`)+1 bits. Push when full cannot occur; an assertion guards it.
- PC arithmetic: 32-bit, wraps at 2^32. Bits [1:0] are passed through unchanged and not checked.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_inst`=0, queue empty, `drop`=0, state BOOT.
- Reset asserted mid-transaction: all state returns to reset values next edge. A later `imem_rvalid` from the killed request is ignored because the FSM is not in WAIT.
- Minimum fetch latency: grant at cycle N, `imem_rvalid` at N+1, `if_valid` at N+2. `if_*` come from registered queue outputs.
- Throughput: one instruction per 2 cycles (single outstanding request).
- `fetch_pc` changes only on a grant or a redirect, so the predictor sees a stable `pc` while a request is pending.

## Configuration
- `FETCH_PERF_EN`
  - Defined: adds outputs `perf_fetched` (32, pushes) and `perf_dropped` (32, words discarded via `drop` or same-cycle redirect). Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset then boot:
  - `rst`=0 for 3 cycles, then 1, `imem_gnt`=1 with 1-cycle rvalid, `npc`=`fetch_pc`+4 → first `imem_req` 2 cycles after release with addr 0.
  - `if_valid` then shows pc 0, 4, 8 on every second cycle.
- Backpressure: `id_ready`=0 with QDEPTH=2 → exactly 2 entries fill (pc 0, 4), `imem_req` stays 0. Raising `id_ready` drains 0 then 4 in order and fetching resumes at 8.
- Redirect in WAIT: grant for pc 8, `redirect`=1 with `npc`=32'h100 before rvalid → returned word discarded, next request addr 32'h100, `if_pc`=32'h100 is the first valid output.
- Redirect coincident with rvalid, and coincident with a pop of a full queue → no push, queue empty, `drop`=0, next addr = `npc`.
- Wrap: `fetch_pc`=32'hFFFF_FFFC, `npc`=`fetch_pc`+4 → next request addr 0. Pointer wrap verified over 10 push/pop cycles.
- With `FETCH_PERF_EN`: 5 fetched and 1 redirect-dropped → `perf_fetched`=5, `perf_dropped`=1.

Source files
------------

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. Owns the architectural fetch PC, issues one
// outstanding request at a time to instruction memory, and buffers returned
// words in a small circular queue that feeds the decode stage. The branch
// predictor sits beside this unit: fetch_pc drives its pc input and its
// target_pc (already muxed with exception/mispredict targets) comes back as
// npc. A redirect flushes the queue and kills any in-flight response.
//
// Parameters
//   RESET_PC     fetch PC loaded by reset
//   QDEPTH       instruction-queue entries (power of two, >= 2)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active low
//   npc          next PC from the predictor
//   redirect     flush pulse (mispredict or exception)
//   fetch_pc     current fetch PC, to the predictor
//   imem_req     fetch request
//   imem_addr    request address (same as fetch_pc)
//   imem_gnt     request accepted this cycle
//   imem_rvalid  response valid (never earlier than the cycle after grant)
//   imem_rdata   returned instruction word
//   if_valid     queue head valid
//   if_pc        PC of the queue head
//   if_inst      instruction of the queue head
//   id_ready     decode consumes the head when if_valid & id_ready
//
// Optional feature, enabled by defining FETCH_PERF_EN:
//   perf_fetched  saturating count of words pushed into the queue
//   perf_dropped  saturating count of words discarded after a redirect
//------------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc,
   input  logic        redirect,
   output logic [31:0] fetch_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        id_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_IDLE = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_req_pc;
   logic             r_drop;

   logic [31:0]      r_q_pc   [QDEPTH];
   logic [31:0]      r_q_inst [QDEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   logic             w_redir;
   logic             w_full;
   logic             w_head_vld;
   logic             w_can_req;
   logic             w_grant;
   logic             w_resp;
   logic             w_push;
   logic             w_pop;

   //---------------------------------------------------------------------------
   // Control decode
   //---------------------------------------------------------------------------
   // Redirect is ignored during the boot cycle; the queue is empty and no
   // request can be in flight there.
   assign w_redir    = redirect & (r_state != S_BOOT);
   assign w_full     = (r_count == FULL_CNT);
   assign w_head_vld = (r_count != '0);

   // A request is only issued when a slot is free, so the single outstanding
   // response always has room when it returns. A redirect suppresses the
   // request because npc is about to replace the PC being presented.
   assign w_can_req  = (r_state == S_IDLE) & ~redirect & ~w_full;
   assign w_grant    = w_can_req & imem_gnt;

   assign w_resp     = (r_state == S_WAIT) & imem_rvalid;
   assign w_push     = w_resp & ~r_drop & ~w_redir;
   assign w_pop      = w_head_vld & id_ready & ~w_redir;

   //---------------------------------------------------------------------------
   // FSM
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      imem_req    = 1'b0;
      unique case (r_state)
         S_BOOT: begin
            w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            imem_req = w_can_req;
            if (w_grant) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_BOOT;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Fetch PC, drop flag and queue pointers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_drop     <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         // The PC only moves on a grant or a redirect, so the predictor sees
         // a stable pc while a request is pending.
         if (w_redir || w_grant) begin
            r_fetch_pc <= npc;
         end

         // A response arriving together with the redirect is discarded on the
         // spot, so the flag is only needed when the response is still to come.
         if (w_resp) begin
            r_drop <= 1'b0;
         end else if (w_redir && (r_state == S_WAIT)) begin
            r_drop <= 1'b1;
         end

         if (w_redir) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end
   end

   //---------------------------------------------------------------------------
   // Request PC capture and queue storage (data only, no reset)
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_grant) begin
         r_req_pc <= r_fetch_pc;
      end
      if (w_push) begin
         r_q_pc[r_wptr]   <= r_req_pc;
         r_q_inst[r_wptr] <= imem_rdata;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign fetch_pc  = r_fetch_pc;
   assign imem_addr = r_fetch_pc;

   // Head outputs are forced to zero when the queue is empty so that stale
   // storage contents never reach decode and the reset values are defined.
   assign if_valid  = w_head_vld;
   assign if_pc     = w_head_vld ? r_q_pc[r_rptr]   : 32'h0;
   assign if_inst   = w_head_vld ? r_q_inst[r_rptr] : 32'h0;

`ifdef FETCH_PERF_EN
   //---------------------------------------------------------------------------
   // Performance counters (saturating)
   //---------------------------------------------------------------------------
   logic        w_discard;
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_dropped;

   assign w_discard = w_resp & (r_drop | w_redir);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_perf_fetched <= 32'h0;
         r_perf_dropped <= 32'h0;
      end else begin
         if (w_push && (r_perf_fetched != 32'hFFFF_FFFF)) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (w_discard && (r_perf_dropped != 32'hFFFF_FFFF)) begin
            r_perf_dropped <= r_perf_dropped + 32'd1;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_dropped = r_perf_dropped;
`endif

`ifndef SYNTHESIS
   // The free-slot rule on request issue means a push never meets a full queue.
   a_push_has_slot: assert property (@(posedge clk) disable iff (!rst)
      !(w_push && w_full));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] npc;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        chk;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc;
   logic        redirect;
   logic [31:0] fetch_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        id_ready;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .npc         (npc),
      .redirect    (redirect),
      .fetch_pc    (fetch_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_inst     (if_inst),
      .id_ready    (id_ready)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_dropped (perf_dropped)
`endif
   );

   // Instruction word the memory returns for a given address.
   function automatic logic [31:0] f_inst(input logic [31:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction

   function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] n,
                               input logic g, input logic v, input logic [31:0] d,
                               input logic y, input logic c, input logic eq,
                               input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei);
      vec_t t;
      t.rst = r;   t.redir = rd; t.npc = n;     t.gnt = g;   t.rv = v;
      t.rdata = d; t.rdy = y;    t.chk = c;     t.e_req = eq;
      t.e_addr = ea; t.e_vld = ev; t.e_pc = ep; t.e_inst = ei;
      return t;
   endfunction

   // One clock cycle: drive inputs after the falling edge, check outputs
   // shortly after, then let the rising edge commit the cycle.
   task automatic cyc(input vec_t v, input string nm);
      @(negedge clk);
      rst         = v.rst;
      redirect    = v.redir;
      npc         = v.npc;
      imem_gnt    = v.gnt;
      imem_rvalid = v.rv;
      imem_rdata  = v.rdata;
      id_ready    = v.rdy;
      #1;
      if (v.chk) begin
         n_total++;
         if ({imem_req, imem_addr, fetch_pc, if_valid, if_pc, if_inst} ===
             {v.e_req, v.e_addr, v.e_addr, v.e_vld, v.e_pc, v.e_inst}) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got req=%b addr=%h fpc=%h vld=%b pc=%h inst=%h, expected req=%b addr=%h vld=%b pc=%h inst=%h",
                     nm, imem_req, imem_addr, fetch_pc, if_valid, if_pc, if_inst,
                     v.e_req, v.e_addr, v.e_vld, v.e_pc, v.e_inst);
         end
      end
   endtask

   // Checked cycle with reset released.
   task automatic row(input string nm, input logic rd, input logic [31:0] n,
                      input logic g, input logic v, input logic [31:0] d,
                      input logic y, input logic eq, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ep, input logic [31:0] ei);
      cyc(mk(1'b1, rd, n, g, v, d, y, 1'b1, eq, ea, ev, ep, ei), nm);
   endtask

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Two reset cycles then the boot cycle; leaves the DUT in IDLE at PC 0.
   task automatic boot(input string nm);
      cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0), nm);
      cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0),
          {nm, "_rst"});
      cyc(mk(1'b1, 1'b0, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0),
          {nm, "_boot"});
   endtask

   // n back-to-back fetches from an empty queue in IDLE, decode always ready.
   task automatic stream(input string nm, input logic [31:0] start, input int n);
      logic [31:0] pc;
      for (int k = 0; k < n; k++) begin
         pc = start + 32'(4 * k);
         row($sformatf("%s_i%0d", nm, k), 1'b0, pc + 32'd4, 1'b1, 1'b0, 32'h0, 1'b1,
             1'b1, pc, (k > 0), (k > 0) ? pc - 32'd4 : 32'h0,
             (k > 0) ? f_inst(pc - 32'd4) : 32'h0);
         row($sformatf("%s_w%0d", nm, k), 1'b0, pc + 32'd8, 1'b0, 1'b1, f_inst(pc), 1'b1,
             1'b0, pc + 32'd4, 1'b0, 32'h0, 32'h0);
      end
   endtask

   vec_t tbl [22];

   initial begin
      rst = 1'b0; redirect = 1'b0; npc = 32'h0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;

      // rst, redir, npc, gnt, rv, rdata, rdy, chk | req, addr, vld, pc, inst
      // Reset, boot cycle, streaming at one instruction per two cycles.
      tbl[0]  = mk(0,0,32'h0 ,1,0,32'h0        ,1,0, 0,32'h0,0,32'h0,32'h0);
      tbl[1]  = mk(0,0,32'h0 ,1,0,32'h0        ,1,1, 0,32'h0,0,32'h0,32'h0);
      tbl[2]  = mk(0,0,32'h0 ,1,0,32'h0        ,1,1, 0,32'h0,0,32'h0,32'h0);
      tbl[3]  = mk(1,0,32'h4 ,1,0,32'h0        ,1,1, 0,32'h0,0,32'h0,32'h0);
      tbl[4]  = mk(1,0,32'h4 ,1,0,32'h0        ,1,1, 1,32'h0,0,32'h0,32'h0);
      tbl[5]  = mk(1,0,32'h8 ,1,1,32'hDEAD_0000,1,1, 0,32'h4,0,32'h0,32'h0);
      tbl[6]  = mk(1,0,32'h8 ,1,0,32'h0        ,1,1, 1,32'h4,1,32'h0,32'hDEAD_0000);
      tbl[7]  = mk(1,0,32'hC ,1,1,32'hDEAD_0004,1,1, 0,32'h8,0,32'h0,32'h0);
      tbl[8]  = mk(1,0,32'hC ,1,0,32'h0        ,1,1, 1,32'h8,1,32'h4,32'hDEAD_0004);
      tbl[9]  = mk(1,0,32'h10,1,1,32'hDEAD_0008,1,1, 0,32'hC,0,32'h0,32'h0);
      // Reset while a request could be granted; stray rvalid in BOOT ignored.
      tbl[10] = mk(0,0,32'h10,1,0,32'h0        ,0,1, 1,32'hC,1,32'h8,32'hDEAD_0008);
      tbl[11] = mk(0,0,32'h0 ,1,0,32'h0        ,0,1, 0,32'h0,0,32'h0,32'h0);
      tbl[12] = mk(1,0,32'h4 ,1,1,32'hBAD0_BAD0,0,1, 0,32'h0,0,32'h0,32'h0);
      // Backpressure: two entries fill, request held off, then drain in order.
      tbl[13] = mk(1,0,32'h4 ,1,0,32'h0        ,0,1, 1,32'h0,0,32'h0,32'h0);
      tbl[14] = mk(1,0,32'h8 ,1,1,32'hDEAD_0000,0,1, 0,32'h4,0,32'h0,32'h0);
      tbl[15] = mk(1,0,32'h8 ,1,0,32'h0        ,0,1, 1,32'h4,1,32'h0,32'hDEAD_0000);
      tbl[16] = mk(1,0,32'hC ,1,1,32'hDEAD_0004,0,1, 0,32'h8,1,32'h0,32'hDEAD_0000);
      tbl[17] = mk(1,0,32'hC ,1,0,32'h0        ,0,1, 0,32'h8,1,32'h0,32'hDEAD_0000);
      tbl[18] = mk(1,0,32'hC ,1,0,32'h0        ,1,1, 0,32'h8,1,32'h0,32'hDEAD_0000);
      tbl[19] = mk(1,0,32'hC ,1,0,32'h0        ,1,1, 1,32'h8,1,32'h4,32'hDEAD_0004);
      tbl[20] = mk(1,0,32'h10,1,1,32'hDEAD_0008,1,1, 0,32'hC,0,32'h0,32'h0);
      tbl[21] = mk(1,0,32'h10,0,0,32'h0        ,0,1, 1,32'hC,1,32'h8,32'hDEAD_0008);

      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i], $sformatf("vec%0d", i));
      end

      // Redirect while waiting for the pc 8 response.
      boot("redir_wait");
      row("rw_g0",   0, 32'h4,   1, 0, 32'h0,        1, 1, 32'h0,   0, 32'h0, 32'h0);
      row("rw_r0",   0, 32'h8,   0, 1, 32'hDEAD_0000, 1, 0, 32'h4,   0, 32'h0, 32'h0);
      row("rw_g4",   0, 32'h8,   1, 0, 32'h0,        1, 1, 32'h4,   1, 32'h0, 32'hDEAD_0000);
      row("rw_r4",   0, 32'hC,   0, 1, 32'hDEAD_0004, 1, 0, 32'h8,   0, 32'h0, 32'h0);
      row("rw_g8",   0, 32'hC,   1, 0, 32'h0,        0, 1, 32'h8,   1, 32'h4, 32'hDEAD_0004);
      row("rw_redir",1, 32'h100, 0, 0, 32'h0,        1, 0, 32'hC,   1, 32'h4, 32'hDEAD_0004);
      row("rw_drop", 0, 32'h104, 0, 1, 32'hDEAD_0008, 1, 0, 32'h100, 0, 32'h0, 32'h0);
      row("rw_g100", 0, 32'h104, 1, 0, 32'h0,        1, 1, 32'h100, 0, 32'h0, 32'h0);
      row("rw_r100", 0, 32'h108, 0, 1, 32'hDEAD_0100, 1, 0, 32'h104, 0, 32'h0, 32'h0);
      row("rw_out",  0, 32'h108, 0, 0, 32'h0,        0, 1, 32'h104, 1, 32'h100, 32'hDEAD_0100);

      // Redirect with a full queue and a pop, then coincident with rvalid.
      row("rf_g104", 0, 32'h108, 1, 0, 32'h0,        0, 1, 32'h104, 1, 32'h100, 32'hDEAD_0100);
      row("rf_r104", 0, 32'h108, 0, 1, 32'hDEAD_0104, 0, 0, 32'h108, 1, 32'h100, 32'hDEAD_0100);
      row("rf_full", 1, 32'h200, 1, 0, 32'h0,        1, 0, 32'h108, 1, 32'h100, 32'hDEAD_0100);
      row("rf_g200", 0, 32'h204, 1, 0, 32'h0,        1, 1, 32'h200, 0, 32'h0,   32'h0);
      row("rf_rvrd", 1, 32'h300, 0, 1, 32'hDEAD_0200, 1, 0, 32'h204, 0, 32'h0,   32'h0);
      row("rf_g300", 0, 32'h304, 1, 0, 32'h0,        1, 1, 32'h300, 0, 32'h0,   32'h0);
      row("rf_r300", 0, 32'h308, 0, 1, 32'hDEAD_0300, 1, 0, 32'h304, 0, 32'h0,   32'h0);
      row("rf_out",  0, 32'h308, 0, 0, 32'h0,        1, 1, 32'h304, 1, 32'h300, 32'hDEAD_0300);
      row("rf_idle", 1, 32'hFFFF_FFFC, 1, 0, 32'h0,  1, 0, 32'h304, 0, 32'h0,   32'h0);

      // PC wrap at 2^32, then ten fetches to cycle the queue pointers.
      row("wr_gtop", 0, 32'h0, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
      row("wr_rtop", 0, 32'h4, 0, 1, 32'h1234_5678, 1, 0, 32'h0, 0, 32'h0, 32'h0);
      row("wr_out",  0, 32'h4, 0, 0, 32'h0,         1, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h1234_5678);
      stream("wr", 32'h0, 10);
      row("wr_end",  0, 32'h0, 0, 0, 32'h0,         1, 1, 32'h28, 1, 32'h24, f_inst(32'h24));

      // Five fetched words then one discarded by a redirect that meets rvalid.
      boot("perf");
`ifdef FETCH_PERF_EN
      check32("perf_fetched_rst", perf_fetched, 32'd0);
      check32("perf_dropped_rst", perf_dropped, 32'd0);
`endif
      stream("pf", 32'h0, 5);
      row("pf_g14", 0, 32'h18,  1, 0, 32'h0,          1, 1, 32'h14,  1, 32'h10, f_inst(32'h10));
      row("pf_drp", 1, 32'h400, 0, 1, f_inst(32'h14), 1, 0, 32'h18,  0, 32'h0,  32'h0);
      row("pf_end", 0, 32'h404, 0, 0, 32'h0,          1, 1, 32'h400, 0, 32'h0,  32'h0);
`ifdef FETCH_PERF_EN
      check32("perf_fetched", perf_fetched, 32'd5);
      check32("perf_dropped", perf_dropped, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
